// File: rtl/cache_types_pkg.sv
// rtl/cache_types_pkg.sv - shared widths and adapter state encoding for the cache line adapter
package cache_types_pkg;

    localparam int LINE_W = 256;
    localparam int BEAT_W = 64;
    localparam int BEATS  = 4;

    // Beat index of the final beat of a line transfer.
    localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } adapter_state_t;

endpackage

// File: rtl/cacheline_adapter.sv
// rtl/cacheline_adapter.sv - bridges a 256-bit cache line port to a 64-bit four-beat memory burst port
//
// Purpose: a line fill collects four 64-bit memory beats into the line buffer;
// a write-back latches a 256-bit line and replays it as four beats. The cache
// sees a single one-cycle resp_o per line transfer.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   line_i       write-back line from cache
//   line_o       line buffer contents (fill result) to cache
//   address_i    line address from cache
//   read_i       cache line-read request (level, held until resp_o)
//   write_i      cache line-write request (level, held until resp_o)
//   resp_o       one-cycle completion pulse to cache
//   burst_i      read beat from memory
//   burst_o      write beat to memory
//   address_o    line-aligned burst address to memory
//   read_o       memory burst read request
//   write_o      memory burst write request
//   resp_i       memory beat acknowledge, one per beat
module cacheline_adapter
    import cache_types_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [LINE_W-1:0] line_i,
    output logic [LINE_W-1:0] line_o,
    input  logic [31:0]       address_i,
    input  logic              read_i,
    input  logic              write_i,
    output logic              resp_o,
    input  logic [BEAT_W-1:0] burst_i,
    output logic [BEAT_W-1:0] burst_o,
    output logic [31:0]       address_o,
    output logic              read_o,
    output logic              write_o,
    input  logic              resp_i
);

    adapter_state_t    state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [LINE_W-1:0] buf_q, buf_d;
    logic [31:0]       addr_q, addr_d;

    // Bit offset of the current beat inside the line buffer.
    logic [7:0]        beat_ofs;
    assign beat_ofs = {cnt_q, 6'b0};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            buf_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        addr_d  = addr_q;
        read_o  = 1'b0;
        write_o = 1'b0;
        resp_o  = 1'b0;
        burst_o = '0;

        unique case (state_q)
            IDLE: begin
                // Write wins over read; resp_i is deliberately not looked at here.
                if (write_i) begin
                    buf_d   = line_i;
                    addr_d  = address_i;
                    cnt_d   = 2'd0;
                    state_d = WRITE;
                end else if (read_i) begin
                    addr_d  = address_i;
                    cnt_d   = 2'd0;
                    state_d = READ;
                end
            end

            READ: begin
                read_o = 1'b1;
                if (resp_i) begin
                    buf_d[beat_ofs +: BEAT_W] = burst_i;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == LAST_BEAT) begin
                        state_d = DONE;
                    end
                end
            end

            WRITE: begin
                write_o = 1'b1;
                burst_o = buf_q[beat_ofs +: BEAT_W];
                if (resp_i) begin
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == LAST_BEAT) begin
                        state_d = DONE;
                    end
                end
            end

            DONE: begin
                // Requests are not sampled here: the cache is still holding the
                // level it raised for the transfer that just completed.
                resp_o  = 1'b1;
                cnt_d   = 2'd0;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign address_o = {addr_q[31:5], 5'b0};
    assign line_o    = buf_q;

endmodule

// File: tb/tb_cacheline_adapter.sv
// tb/tb_cacheline_adapter.sv - self-checking bench for cacheline_adapter
module tb_cacheline_adapter;

    logic         clk;
    logic         rst;
    logic [255:0] line_i;
    logic [255:0] line_o;
    logic [31:0]  address_i;
    logic         read_i;
    logic         write_i;
    logic         resp_o;
    logic [63:0]  burst_i;
    logic [63:0]  burst_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic         resp_i;

    int checks;
    int failures;

    cacheline_adapter dut (
        .clk       (clk),
        .rst       (rst),
        .line_i    (line_i),
        .line_o    (line_o),
        .address_i (address_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .resp_o    (resp_o),
        .burst_i   (burst_i),
        .burst_o   (burst_o),
        .address_o (address_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .resp_i    (resp_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [63:0] B1 = 64'h1111_1111_1111_1111;
    localparam logic [63:0] B2 = 64'h2222_2222_2222_2222;
    localparam logic [63:0] B3 = 64'h3333_3333_3333_3333;
    localparam logic [63:0] B4 = 64'h4444_4444_4444_4444;
    localparam logic [63:0] D0 = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] D1 = 64'hFEDC_BA98_7654_3210;
    localparam logic [63:0] D2 = 64'hA5A5_5A5A_0F0F_F0F0;
    localparam logic [63:0] D3 = 64'hDEAD_BEEF_CAFE_F00D;
    localparam logic [63:0] JUNK = 64'hBAD0_BAD0_BAD0_BAD0;

    typedef struct {
        logic         rd;
        logic         wr;
        logic         rsp;
        logic [63:0]  bi;
        logic [255:0] li;
        logic [31:0]  ai;
        logic         e_rd;
        logic         e_wr;
        logic         e_rsp;
        logic [63:0]  e_bo;
        logic [31:0]  e_ao;
        logic         chk_line;
        logic [255:0] e_line;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic add_vec(input logic rd, input logic wr, input logic rsp, input logic [63:0] bi,
                           input logic [255:0] li, input logic [31:0] ai,
                           input logic e_rd, input logic e_wr, input logic e_rsp,
                           input logic [63:0] e_bo, input logic [31:0] e_ao,
                           input logic chk_line, input logic [255:0] e_line);
        vec_t v;
        v.rd = rd; v.wr = wr; v.rsp = rsp; v.bi = bi; v.li = li; v.ai = ai;
        v.e_rd = e_rd; v.e_wr = e_wr; v.e_rsp = e_rsp; v.e_bo = e_bo; v.e_ao = e_ao;
        v.chk_line = chk_line; v.e_line = e_line;
        vecs.push_back(v);
    endtask

    task automatic chk_outs(input string tag, input logic e_rd, input logic e_wr, input logic e_rsp,
                            input logic [63:0] e_bo);
        chk({tag, ".read_o"},  256'(read_o),  256'(e_rd));
        chk({tag, ".write_o"}, 256'(write_o), 256'(e_wr));
        chk({tag, ".resp_o"},  256'(resp_o),  256'(e_rsp));
        chk({tag, ".burst_o"}, 256'(burst_o), 256'(e_bo));
    endtask

    initial begin
        logic [255:0] lw;
        logic [255:0] lw2;
        logic [255:0] lr;
        logic [6:0]   pat;
        logic [63:0]  gb [4];
        int           k;

        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        line_i    = '0;
        address_i = '0;
        read_i    = 1'b0;
        write_i   = 1'b0;
        burst_i   = '0;
        resp_i    = 1'b0;

        lw  = {D3, D2, D1, D0};
        lw2 = {D0, D3, D1, D2};
        lr  = {B4, B3, B2, B1};

        cyc();
        cyc();
        chk_outs("reset", 1'b0, 1'b0, 1'b0, 64'h0);
        chk("reset.address_o", 256'(address_o), 256'h0);
        chk("reset.line_o", line_o, 256'h0);
        rst = 1'b0;

        // Read fill, then write-back; each entry is one cycle: inputs driven and
        // outputs expected during that cycle.
        //       rd wr rsp bi     li  ai             e_rd e_wr e_rsp e_bo e_ao          chk e_line
        add_vec(1, 0, 0, JUNK, '0, 32'h0000_1234, 0, 0, 0, '0, 32'h0000_0000, 1, '0);
        add_vec(1, 0, 1, B1,   '0, 32'h0000_1234, 1, 0, 0, '0, 32'h0000_1220, 0, '0);
        add_vec(1, 0, 1, B2,   '0, 32'h0000_1234, 1, 0, 0, '0, 32'h0000_1220, 0, '0);
        add_vec(1, 0, 1, B3,   '0, 32'h0000_1234, 1, 0, 0, '0, 32'h0000_1220, 0, '0);
        add_vec(1, 0, 1, B4,   '0, 32'h0000_1234, 1, 0, 0, '0, 32'h0000_1220, 0, '0);
        add_vec(1, 0, 0, JUNK, '0, 32'h0000_1234, 0, 0, 1, '0, 32'h0000_1220, 1, lr);
        add_vec(0, 0, 0, JUNK, '0, 32'h0,         0, 0, 0, '0, 32'h0000_1220, 1, lr);
        add_vec(0, 1, 0, JUNK, lw, 32'h0000_ABCD, 0, 0, 0, '0, 32'h0000_1220, 0, '0);
        add_vec(0, 1, 1, JUNK, lw, 32'h0000_ABCD, 0, 1, 0, D0, 32'h0000_ABC0, 1, lw);
        add_vec(0, 1, 1, JUNK, lw, 32'h0000_ABCD, 0, 1, 0, D1, 32'h0000_ABC0, 0, '0);
        add_vec(0, 1, 1, JUNK, lw, 32'h0000_ABCD, 0, 1, 0, D2, 32'h0000_ABC0, 0, '0);
        add_vec(0, 1, 1, JUNK, lw, 32'h0000_ABCD, 0, 1, 0, D3, 32'h0000_ABC0, 0, '0);
        add_vec(0, 1, 0, JUNK, lw, 32'h0000_ABCD, 0, 0, 1, '0, 32'h0000_ABC0, 0, '0);
        add_vec(0, 0, 0, JUNK, '0, 32'h0,         0, 0, 0, '0, 32'h0000_ABC0, 1, lw);

        for (int i = 0; i < vecs.size(); i++) begin
            read_i    = vecs[i].rd;
            write_i   = vecs[i].wr;
            resp_i    = vecs[i].rsp;
            burst_i   = vecs[i].bi;
            line_i    = vecs[i].li;
            address_i = vecs[i].ai;
            chk_outs($sformatf("vec%0d", i), vecs[i].e_rd, vecs[i].e_wr, vecs[i].e_rsp, vecs[i].e_bo);
            chk($sformatf("vec%0d.address_o", i), 256'(address_o), 256'(vecs[i].e_ao));
            if (vecs[i].chk_line) begin
                chk($sformatf("vec%0d.line_o", i), line_o, vecs[i].e_line);
            end
            cyc();
        end

        // Spurious resp_i in IDLE: nothing changes, line_o keeps the written line.
        resp_i  = 1'b1;
        burst_i = JUNK;
        cyc();
        cyc();
        chk_outs("spurious", 1'b0, 1'b0, 1'b0, 64'h0);
        chk("spurious.line_o", line_o, lw);
        resp_i = 1'b0;

        // Gapped read burst: resp_i pattern 1,0,0,1,1,0,1 (applied LSB first).
        gb[0] = 64'h0A0A_0000_0000_0001;
        gb[1] = 64'h0B0B_0000_0000_0002;
        gb[2] = 64'h0C0C_0000_0000_0003;
        gb[3] = 64'h0D0D_0000_0000_0004;
        pat = 7'b1011001;
        read_i    = 1'b1;
        address_i = 32'h8000_0FFF;
        cyc();
        k = 0;
        for (int i = 0; i < 7; i++) begin
            resp_i  = pat[i];
            burst_i = pat[i] ? gb[k] : JUNK;
            chk($sformatf("gap%0d.read_o", i), 256'(read_o), 256'h1);
            chk($sformatf("gap%0d.resp_o", i), 256'(resp_o), 256'h0);
            cyc();
            if (pat[i]) k++;
        end
        resp_i  = 1'b0;
        burst_i = JUNK;
        chk_outs("gap.done", 1'b0, 1'b0, 1'b1, 64'h0);
        chk("gap.address_o", 256'(address_o), 256'h8000_0FE0);
        chk("gap.line_o", line_o, {gb[3], gb[2], gb[1], gb[0]});
        cyc();
        read_i = 1'b0;
        chk("gap.resp_low", 256'(resp_o), 256'h0);
        cyc();

        // Simultaneous read+write: write path wins, read_o never rises.
        read_i    = 1'b1;
        write_i   = 1'b1;
        line_i    = lw2;
        address_i = 32'h0000_0040;
        cyc();
        for (int i = 0; i < 4; i++) begin
            resp_i = 1'b1;
            chk_outs($sformatf("both%0d", i), 1'b0, 1'b1, 1'b0, lw2[64*i +: 64]);
            cyc();
        end
        resp_i = 1'b0;
        chk_outs("both.done", 1'b0, 1'b0, 1'b1, 64'h0);
        cyc();
        read_i  = 1'b0;
        write_i = 1'b0;
        chk_outs("both.idle", 1'b0, 1'b0, 1'b0, 64'h0);
        cyc();

        // Reset after two beats of a read; a beat arriving with and after reset is dropped.
        read_i    = 1'b1;
        address_i = 32'h0000_2000;
        cyc();
        resp_i  = 1'b1;
        burst_i = B1;
        cyc();
        burst_i = B2;
        cyc();
        rst     = 1'b1;
        burst_i = B3;
        read_i  = 1'b0;
        cyc();
        rst     = 1'b0;
        burst_i = B4;
        chk_outs("rst", 1'b0, 1'b0, 1'b0, 64'h0);
        chk("rst.address_o", 256'(address_o), 256'h0);
        chk("rst.line_o", line_o, 256'h0);
        cyc();
        resp_i = 1'b0;
        chk_outs("rst.after", 1'b0, 1'b0, 1'b0, 64'h0);
        chk("rst.after.line_o", line_o, 256'h0);

        // A fresh read after reset starts again at beat 0.
        read_i    = 1'b1;
        address_i = 32'h0000_3010;
        cyc();
        for (int i = 0; i < 4; i++) begin
            resp_i  = 1'b1;
            burst_i = gb[3 - i];
            chk($sformatf("rd2_%0d.read_o", i), 256'(read_o), 256'h1);
            cyc();
        end
        resp_i = 1'b0;
        chk_outs("rd2.done", 1'b0, 1'b0, 1'b1, 64'h0);
        chk("rd2.address_o", 256'(address_o), 256'h0000_3000);
        chk("rd2.line_o", line_o, {gb[0], gb[1], gb[2], gb[3]});
        cyc();
        read_i = 1'b0;
        chk_outs("rd2.idle", 1'b0, 1'b0, 1'b0, 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
